// File: rtl/cache_controller_fsm_pkg.sv
// Shared types and geometry for the cache request controller.
package cache_controller_fsm_pkg;

   localparam int NUM_WAYS  = 4;
   localparam int AGE_W     = 2;
   localparam int INDEX_W   = 7;
   localparam int WAY_IDX_W = $clog2(NUM_WAYS);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WR_HIT,
      RD_UPD,
      MEM_REQ,
      MEM_WAIT,
      FILL,
      RESP
   } state_t;

   // Age field of way k inside the packed age vector
   function automatic logic [AGE_W-1:0] way_age(input logic [NUM_WAYS*AGE_W-1:0] ages,
                                                input int k);
      return ages[k*AGE_W +: AGE_W];
   endfunction

endpackage

// File: rtl/cache_controller_fsm_lru_policy.sv
// Combinational 2-bit age LRU helper: promotion update vector and replacement victim.
module lru_policy
   import cache_controller_fsm_pkg::*;
(
   input  logic [NUM_WAYS*AGE_W-1:0] ages,
   input  logic [NUM_WAYS-1:0]       way,
   input  logic                      allocate,
   output logic [NUM_WAYS-1:0]       reset_age,
   output logic [NUM_WAYS-1:0]       increment_age,
   output logic [NUM_WAYS-1:0]       victim
);

   logic [AGE_W-1:0]     ref_age;
   logic [AGE_W-1:0]     max_age;
   logic [WAY_IDX_W-1:0] max_idx;

   // Reference age of the promoted way; a freshly allocated line counts as the oldest possible
   always_comb begin
      ref_age = '0;
      for (int k = 0; k < NUM_WAYS; k++) begin
         if (way[k]) ref_age = ref_age | way_age(ages, k);
      end
      if (allocate) ref_age = '1;
   end

   // Promoted way goes to age 0; every other way younger than it ages by one
   always_comb begin
      reset_age     = way;
      increment_age = '0;
      for (int k = 0; k < NUM_WAYS; k++) begin
         increment_age[k] = !way[k] && (way_age(ages, k) < ref_age);
      end
   end

   // Victim is the oldest way, lowest index on ties
   always_comb begin
      max_age = way_age(ages, 0);
      max_idx = '0;
      for (int k = 1; k < NUM_WAYS; k++) begin
         if (way_age(ages, k) > max_age) begin
            max_age = way_age(ages, k);
            max_idx = WAY_IDX_W'(k);
         end
      end
      victim          = '0;
      victim[max_idx] = 1'b1;
   end

endmodule

// File: rtl/cache_controller_fsm.sv
// Request-side controller for the 4-way cache array: lookup, LRU age update,
// write-through with no write allocate, and single-byte read-miss fill.
module cache_controller_fsm
   import cache_controller_fsm_pkg::*;
#(
   parameter int ADDRESS_WORD_SIZE = 32,
   parameter int TAG_SIZE          = 19,
   parameter int CNT_W             = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpu_req_valid,
   output logic                         cpu_req_ready,
   input  logic                         cpu_req_we,
   input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
   input  logic [7:0]                   cpu_wdata,
   output logic                         cpu_resp_valid,
   input  logic                         cpu_resp_ready,
   output logic [7:0]                   cpu_rdata,
   output logic                         cpu_resp_hit,
   output logic [ADDRESS_WORD_SIZE-1:0] address_word,
   output logic                         try_read,
   output logic                         try_write,
   output logic [7:0]                   write_data,
   output logic [NUM_WAYS-1:0]          reset_age,
   output logic [NUM_WAYS-1:0]          increment_age,
   input  logic [7:0]                   data,
   input  logic [NUM_WAYS*AGE_W-1:0]    ages,
   input  logic                         hit_miss,
   input  logic [NUM_WAYS-1:0]          hit_miss_set,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_we,
   output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
   output logic [7:0]                   mem_wdata,
   input  logic                         mem_rsp_valid,
   input  logic [7:0]                   mem_rsp_data,
   output logic [CNT_W-1:0]             hit_count,
   output logic [CNT_W-1:0]             miss_count
);

   // The set index sits just below the tag inside address_word
   if (ADDRESS_WORD_SIZE - TAG_SIZE < INDEX_W) begin : g_bad_geometry
      $error("address too narrow for tag plus set index");
   end

   state_t                    state;
   logic                      we_q;
   logic [7:0]                wdata_q;
   logic [7:0]                data_q;
   logic [7:0]                rsp_q;
   logic                      hit_q;
   logic [NUM_WAYS*AGE_W-1:0] ages_q;
   logic [NUM_WAYS-1:0]       way_q;

   logic [NUM_WAYS*AGE_W-1:0] lru_ages;
   logic [NUM_WAYS-1:0]       lru_way;
   logic                      lru_alloc;
   logic [NUM_WAYS-1:0]       lru_reset;
   logic [NUM_WAYS-1:0]       lru_inc;
   logic [NUM_WAYS-1:0]       lru_victim;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Live array outputs are used only while looking up; afterwards the captured copies drive the LRU
   assign lru_ages  = (state == LOOKUP) ? ages : ages_q;
   assign lru_way   = (state == LOOKUP) ? hit_miss_set : way_q;
   assign lru_alloc = (state == MEM_WAIT);

   lru_policy u_lru (
      .ages          (lru_ages),
      .way           (lru_way),
      .allocate      (lru_alloc),
      .reset_age     (lru_reset),
      .increment_age (lru_inc),
      .victim        (lru_victim)
   );

   // Controller state machine; every output is registered and set on entry to the state that owns it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cpu_req_ready  <= 1'b1;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         cpu_resp_hit   <= 1'b0;
         address_word   <= '0;
         try_read       <= 1'b0;
         try_write      <= 1'b0;
         write_data     <= '0;
         reset_age      <= '0;
         increment_age  <= '0;
         mem_req_valid  <= 1'b0;
         mem_req_we     <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         hit_count      <= '0;
         miss_count     <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         data_q         <= '0;
         rsp_q          <= '0;
         hit_q          <= 1'b0;
         ages_q         <= '0;
         way_q          <= '0;
      end else begin
         try_read      <= 1'b0;
         try_write     <= 1'b0;
         reset_age     <= '0;
         increment_age <= '0;
         case (state)
            IDLE: begin
               if (cpu_req_valid && cpu_req_ready) begin
                  address_word  <= cpu_addr;
                  we_q          <= cpu_req_we;
                  wdata_q       <= cpu_wdata;
                  cpu_req_ready <= 1'b0;
                  try_read      <= 1'b1;
                  state         <= LOOKUP;
               end
            end
            LOOKUP: begin
               hit_q  <= hit_miss;
               data_q <= data;
               ages_q <= ages;
               if (hit_miss) begin
                  hit_count     <= sat_inc(hit_count);
                  way_q         <= hit_miss_set;
                  reset_age     <= lru_reset;
                  increment_age <= lru_inc;
                  if (we_q) begin
                     try_write  <= 1'b1;
                     write_data <= wdata_q;
                     state      <= WR_HIT;
                  end else begin
                     state <= RD_UPD;
                  end
               end else begin
                  // Remember the replacement way now, while the ages are being sampled
                  miss_count    <= sat_inc(miss_count);
                  way_q         <= lru_victim;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= we_q;
                  mem_addr      <= address_word;
                  mem_wdata     <= we_q ? wdata_q : 8'h00;
                  state         <= MEM_REQ;
               end
            end
            RD_UPD: begin
               cpu_resp_valid <= 1'b1;
               cpu_rdata      <= data_q;
               cpu_resp_hit   <= 1'b1;
               state          <= RESP;
            end
            WR_HIT: begin
               mem_req_valid <= 1'b1;
               mem_req_we    <= 1'b1;
               mem_addr      <= address_word;
               mem_wdata     <= wdata_q;
               state         <= MEM_REQ;
            end
            MEM_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_req_we    <= 1'b0;
                  if (we_q) begin
                     cpu_resp_valid <= 1'b1;
                     cpu_rdata      <= 8'h00;
                     cpu_resp_hit   <= hit_q;
                     state          <= RESP;
                  end else begin
                     state <= MEM_WAIT;
                  end
               end
            end
            MEM_WAIT: begin
               if (mem_rsp_valid) begin
                  rsp_q         <= mem_rsp_data;
                  try_write     <= 1'b1;
                  write_data    <= mem_rsp_data;
                  reset_age     <= lru_reset;
                  increment_age <= lru_inc;
                  state         <= FILL;
               end
            end
            FILL: begin
               cpu_resp_valid <= 1'b1;
               cpu_rdata      <= rsp_q;
               cpu_resp_hit   <= 1'b0;
               state          <= RESP;
            end
            RESP: begin
               if (cpu_resp_ready) begin
                  cpu_resp_valid <= 1'b0;
                  cpu_rdata      <= 8'h00;
                  cpu_resp_hit   <= 1'b0;
                  cpu_req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller_fsm.sv
// Self-checking bench for cache_controller_fsm with a response scoreboard.
module tb_cache_controller_fsm;

   localparam int AW      = 32;
   localparam int TB_CNT  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req_valid;
   logic          cpu_req_ready;
   logic          cpu_req_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_resp_valid;
   logic          cpu_resp_ready;
   logic [7:0]    cpu_rdata;
   logic          cpu_resp_hit;
   logic [AW-1:0] address_word;
   logic          try_read;
   logic          try_write;
   logic [7:0]    write_data;
   logic [3:0]    reset_age;
   logic [3:0]    increment_age;
   logic [7:0]    data;
   logic [7:0]    ages;
   logic          hit_miss;
   logic [3:0]    hit_miss_set;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_rsp_valid;
   logic [7:0]    mem_rsp_data;
   logic [TB_CNT-1:0] hit_count;
   logic [TB_CNT-1:0] miss_count;

   cache_controller_fsm #(
      .ADDRESS_WORD_SIZE (AW),
      .TAG_SIZE          (19),
      .CNT_W             (TB_CNT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_we     (cpu_req_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_resp_ready (cpu_resp_ready),
      .cpu_rdata      (cpu_rdata),
      .cpu_resp_hit   (cpu_resp_hit),
      .address_word   (address_word),
      .try_read       (try_read),
      .try_write      (try_write),
      .write_data     (write_data),
      .reset_age      (reset_age),
      .increment_age  (increment_age),
      .data           (data),
      .ages           (ages),
      .hit_miss       (hit_miss),
      .hit_miss_set   (hit_miss_set),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] rdata;
      logic       hit;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;

   // Observation counters sampled mid-cycle
   int          tw_cnt = 0;
   int          lru_cnt = 0;
   int          memreq_cnt = 0;
   int          unstable_cnt = 0;
   int          both_cnt = 0;
   logic [3:0]  last_reset_age = '0;
   logic [3:0]  last_inc_age = '0;
   logic        last_lru_tw = 1'b0;
   logic [7:0]  last_lru_wdata = '0;
   logic [AW-1:0] last_mem_addr = '0;
   logic        last_mem_we = 1'b0;
   logic [7:0]  last_mem_wdata = '0;
   logic        prev_pending = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic        prev_we = 1'b0;
   logic [7:0]  prev_wdata = '0;

   always @(negedge clk) begin
      if (try_read && try_write) both_cnt++;
      if (try_write) tw_cnt++;
      if (reset_age != 4'b0000) begin
         lru_cnt++;
         last_reset_age = reset_age;
         last_inc_age   = increment_age;
         last_lru_tw    = try_write;
         last_lru_wdata = write_data;
      end
      if (mem_req_valid && mem_req_ready) begin
         memreq_cnt++;
         last_mem_addr  = mem_addr;
         last_mem_we    = mem_req_we;
         last_mem_wdata = mem_wdata;
      end
      if (mem_req_valid && prev_pending &&
          (mem_addr !== prev_addr || mem_req_we !== prev_we || mem_wdata !== prev_wdata))
         unstable_cnt++;
      prev_pending = mem_req_valid && !mem_req_ready;
      prev_addr    = mem_addr;
      prev_we      = mem_req_we;
      prev_wdata   = mem_wdata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cache(input logic h, input logic [3:0] way, input logic [7:0] a,
                            input logic [7:0] d);
      hit_miss     = h;
      hit_miss_set = way;
      ages         = a;
      data         = d;
   endtask

   task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                           output int t_acc, output bit ok);
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_addr      = addr;
      cpu_wdata     = wd;
      ok    = 1'b0;
      t_acc = -1;
      for (int i = 0; i < 20; i++) begin
         if (cpu_req_ready) begin
            t_acc = cyc;
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      cpu_req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int budget, output bit ok, output int t_resp);
      ok     = 1'b0;
      t_resp = -1;
      for (int i = 0; i < budget; i++) begin
         if (cpu_resp_valid) begin
            ok     = 1'b1;
            t_resp = cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic accept_resp;
      cpu_resp_ready = 1'b1;
      tick();
      cpu_resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (cpu_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%0b want=1", cpu_req_ready);
      end
      checks++;
      if ({cpu_resp_valid, cpu_rdata, cpu_resp_hit, try_read, try_write, reset_age,
           increment_age, mem_req_valid, mem_req_we, address_word} !== '0) begin
         failures++;
         $display("FAIL reset_outputs resp_v=%0b tr=%0b tw=%0b ra=%b ia=%b memv=%0b aw=%h want all 0",
                  cpu_resp_valid, try_read, try_write, reset_age, increment_age, mem_req_valid,
                  address_word);
      end
      checks++;
      if (hit_count !== '0 || miss_count !== '0) begin
         failures++;
         $display("FAIL reset_counters hit=%0d miss=%0d want 0/0", hit_count, miss_count);
      end
   endtask

   task automatic test_read_miss;
      int t, tr, m0, l0;
      bit ok;
      exp_t e;
      set_cache(1'b0, 4'b0000, 8'h00, 8'h00);
      m0 = memreq_cnt;
      l0 = lru_cnt;
      sb.push_back('{rdata: 8'hA5, hit: 1'b0});
      send_req(1'b0, 32'h0000_1234, 8'h00, t, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmiss_accept got=timeout want=accept"); end
      tick();
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 8'hA5;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 8'h00;
      wait_resp(20, ok, tr);
      checks++;
      if (!ok || tr !== t + 5) begin
         failures++;
         $display("FAIL rmiss_latency got=%0d want=%0d", tr - t, 5);
      end
      e = sb.pop_front();
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL rmiss_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      checks++;
      if (memreq_cnt - m0 !== 1 || last_mem_addr !== 32'h0000_1234 || last_mem_we !== 1'b0) begin
         failures++;
         $display("FAIL rmiss_memreq got n=%0d addr=%h we=%0b want n=1 addr=00001234 we=0",
                  memreq_cnt - m0, last_mem_addr, last_mem_we);
      end
      checks++;
      if (lru_cnt - l0 !== 1 || last_reset_age !== 4'b0001 || last_inc_age !== 4'b1110 ||
          last_lru_tw !== 1'b1 || last_lru_wdata !== 8'hA5) begin
         failures++;
         $display("FAIL rmiss_fill got n=%0d ra=%b ia=%b tw=%0b wd=%h want n=1 ra=0001 ia=1110 tw=1 wd=a5",
                  lru_cnt - l0, last_reset_age, last_inc_age, last_lru_tw, last_lru_wdata);
      end
      checks++;
      if (hit_count !== 4'd0 || miss_count !== 4'd1) begin
         failures++;
         $display("FAIL rmiss_counters got=%0d/%0d want=0/1", hit_count, miss_count);
      end
      accept_resp();
   endtask

   task automatic test_read_hit;
      int t, tr, m0, l0;
      bit ok;
      exp_t e;
      set_cache(1'b1, 4'b0001, 8'h00, 8'hA5);
      m0 = memreq_cnt;
      l0 = lru_cnt;
      sb.push_back('{rdata: 8'hA5, hit: 1'b1});
      send_req(1'b0, 32'h0000_1234, 8'h00, t, ok);
      wait_resp(20, ok, tr);
      checks++;
      if (!ok || tr !== t + 3) begin
         failures++;
         $display("FAIL rhit_latency got=%0d want=3", tr - t);
      end
      e = sb.pop_front();
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL rhit_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      checks++;
      if (lru_cnt - l0 !== 1 || last_reset_age !== 4'b0001 || last_inc_age !== 4'b0000 ||
          last_lru_tw !== 1'b0 || memreq_cnt !== m0) begin
         failures++;
         $display("FAIL rhit_lru got n=%0d ra=%b ia=%b tw=%0b mem=%0d want n=1 ra=0001 ia=0000 tw=0 mem=0",
                  lru_cnt - l0, last_reset_age, last_inc_age, last_lru_tw, memreq_cnt - m0);
      end
      checks++;
      if (hit_count !== 4'd1 || miss_count !== 4'd1) begin
         failures++;
         $display("FAIL rhit_counters got=%0d/%0d want=1/1", hit_count, miss_count);
      end
      accept_resp();
   endtask

   task automatic test_write_hit;
      int t, tr, m0, l0;
      bit ok;
      exp_t e;
      // way3..0 ages = 3,1,2,0
      set_cache(1'b1, 4'b0100, 8'b11_01_10_00, 8'h77);
      m0 = memreq_cnt;
      l0 = lru_cnt;
      sb.push_back('{rdata: 8'h00, hit: 1'b1});
      send_req(1'b1, 32'h0000_2468, 8'h3C, t, ok);
      wait_resp(20, ok, tr);
      checks++;
      if (!ok || tr !== t + 4) begin
         failures++;
         $display("FAIL whit_latency got=%0d want=4", tr - t);
      end
      e = sb.pop_front();
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL whit_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      checks++;
      if (lru_cnt - l0 !== 1 || last_reset_age !== 4'b0100 || last_inc_age !== 4'b0001 ||
          last_lru_tw !== 1'b1 || last_lru_wdata !== 8'h3C) begin
         failures++;
         $display("FAIL whit_lru got n=%0d ra=%b ia=%b tw=%0b wd=%h want n=1 ra=0100 ia=0001 tw=1 wd=3c",
                  lru_cnt - l0, last_reset_age, last_inc_age, last_lru_tw, last_lru_wdata);
      end
      checks++;
      if (memreq_cnt - m0 !== 1 || last_mem_we !== 1'b1 || last_mem_addr !== 32'h0000_2468 ||
          last_mem_wdata !== 8'h3C) begin
         failures++;
         $display("FAIL whit_memwrite got n=%0d we=%0b addr=%h wd=%h want n=1 we=1 addr=00002468 wd=3c",
                  memreq_cnt - m0, last_mem_we, last_mem_addr, last_mem_wdata);
      end
      checks++;
      if (hit_count !== 4'd2) begin
         failures++;
         $display("FAIL whit_hitcount got=%0d want=2", hit_count);
      end
      accept_resp();
   endtask

   task automatic test_write_miss;
      int t, tr, m0, l0, w0, u0;
      bit ok;
      exp_t e;
      set_cache(1'b0, 4'b0000, 8'h1B, 8'h00);
      m0 = memreq_cnt;
      l0 = lru_cnt;
      w0 = tw_cnt;
      u0 = unstable_cnt;
      mem_req_ready = 1'b0;
      sb.push_back('{rdata: 8'h00, hit: 1'b0});
      send_req(1'b1, 32'h0000_ABCD, 8'h5A, t, ok);
      repeat (4) tick();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_ABCD || mem_wdata !== 8'h5A) begin
         failures++;
         $display("FAIL wmiss_hold got v=%0b addr=%h wd=%h want v=1 addr=0000abcd wd=5a",
                  mem_req_valid, mem_addr, mem_wdata);
      end
      mem_req_ready = 1'b1;
      wait_resp(20, ok, tr);
      checks++;
      if (!ok) begin failures++; $display("FAIL wmiss_resp_timeout got=none want=resp"); end
      e = sb.pop_front();
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL wmiss_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      checks++;
      if (memreq_cnt - m0 !== 1 || last_mem_we !== 1'b1 || last_mem_wdata !== 8'h5A ||
          unstable_cnt !== u0) begin
         failures++;
         $display("FAIL wmiss_memwrite got n=%0d we=%0b wd=%h unstable=%0d want n=1 we=1 wd=5a unstable=0",
                  memreq_cnt - m0, last_mem_we, last_mem_wdata, unstable_cnt - u0);
      end
      checks++;
      if (tw_cnt !== w0 || lru_cnt !== l0) begin
         failures++;
         $display("FAIL wmiss_no_alloc got tw=%0d lru=%0d want 0/0", tw_cnt - w0, lru_cnt - l0);
      end
      checks++;
      if (miss_count !== 4'd2) begin
         failures++;
         $display("FAIL wmiss_misscount got=%0d want=2", miss_count);
      end
      accept_resp();
   endtask

   task automatic test_reset_mid;
      int t, tr, w0, bad;
      bit ok;
      exp_t e;
      set_cache(1'b0, 4'b0000, 8'h00, 8'h00);
      send_req(1'b0, 32'h0000_0F00, 8'h00, t, ok);
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (cpu_req_ready !== 1'b1 ||
          {cpu_resp_valid, cpu_rdata, try_read, try_write, reset_age, increment_age,
           mem_req_valid, mem_addr, address_word, hit_count, miss_count} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got rdy=%0b resp_v=%0b memv=%0b aw=%h hit=%0d miss=%0d want 1/0/0/0/0/0",
                  cpu_req_ready, cpu_resp_valid, mem_req_valid, address_word, hit_count, miss_count);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      w0 = tw_cnt;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 8'h99;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 8'h00;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (cpu_resp_valid || !cpu_req_ready) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || tw_cnt !== w0) begin
         failures++;
         $display("FAIL midreset_stray_rsp got bad=%0d tw=%0d want 0/0", bad, tw_cnt - w0);
      end
      set_cache(1'b1, 4'b0010, 8'h00, 8'h42);
      sb.push_back('{rdata: 8'h42, hit: 1'b1});
      send_req(1'b0, 32'h0000_0F00, 8'h00, t, ok);
      wait_resp(20, ok, tr);
      checks++;
      if (!ok || tr !== t + 3) begin
         failures++;
         $display("FAIL midreset_next_latency got=%0d want=3", tr - t);
      end
      e = sb.pop_front();
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL midreset_next_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      checks++;
      if (hit_count !== 4'd1 || miss_count !== 4'd0) begin
         failures++;
         $display("FAIL midreset_counters got=%0d/%0d want=1/0", hit_count, miss_count);
      end
      accept_resp();
   endtask

   task automatic test_resp_backpressure;
      int t, tr, bad;
      bit ok;
      exp_t e;
      set_cache(1'b1, 4'b0001, 8'h00, 8'h6E);
      sb.push_back('{rdata: 8'h6E, hit: 1'b1});
      send_req(1'b0, 32'h0000_3000, 8'h00, t, ok);
      wait_resp(20, ok, tr);
      cpu_req_valid = 1'b1;
      cpu_req_we    = 1'b0;
      cpu_addr      = 32'h0000_4000;
      e = sb.pop_front();
      bad = ok ? 0 : 1;
      for (int i = 0; i < 5; i++) begin
         if (cpu_resp_valid !== 1'b1 || cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit ||
             cpu_req_ready !== 1'b0 || try_read !== 1'b0) bad++;
         tick();
      end
      cpu_req_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold got bad_cycles=%0d want=0", bad);
      end
      checks++;
      if (cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) begin
         failures++;
         $display("FAIL backpressure_resp got=%h/%0b want=%h/%0b", cpu_rdata, cpu_resp_hit, e.rdata, e.hit);
      end
      accept_resp();
      checks++;
      if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release got rdy=%0b resp_v=%0b want 1/0", cpu_req_ready, cpu_resp_valid);
      end
   endtask

   task automatic test_saturation;
      int t, tr, bad;
      bit ok;
      exp_t e;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         set_cache(1'b1, 4'b1000, 8'h00, 8'(i + 16));
         sb.push_back('{rdata: 8'(i + 16), hit: 1'b1});
         send_req(1'b0, 32'h0000_5000 + i, 8'h00, t, ok);
         wait_resp(20, ok, tr);
         e = sb.pop_front();
         if (!ok || cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) bad++;
         accept_resp();
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL sat_hit_txns got bad=%0d want=0", bad); end
      checks++;
      if (hit_count !== 4'hF) begin
         failures++;
         $display("FAIL sat_hit_count got=%0d want=15", hit_count);
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         set_cache(1'b0, 4'b0000, 8'h00, 8'h00);
         sb.push_back('{rdata: 8'h00, hit: 1'b0});
         send_req(1'b1, 32'h0000_6000 + i, 8'(i), t, ok);
         wait_resp(20, ok, tr);
         e = sb.pop_front();
         if (!ok || cpu_rdata !== e.rdata || cpu_resp_hit !== e.hit) bad++;
         accept_resp();
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL sat_miss_txns got bad=%0d want=0", bad); end
      checks++;
      if (miss_count !== 4'hF || hit_count !== 4'hF) begin
         failures++;
         $display("FAIL sat_miss_count got=%0d/%0d want=15/15", hit_count, miss_count);
      end
   endtask

   initial begin
      rst            = 1'b1;
      cpu_req_valid  = 1'b0;
      cpu_req_we     = 1'b0;
      cpu_addr       = '0;
      cpu_wdata      = '0;
      cpu_resp_ready = 1'b0;
      data           = '0;
      ages           = '0;
      hit_miss       = 1'b0;
      hit_miss_set   = '0;
      mem_req_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_reset_mid();
      test_resp_backpressure();
      test_saturation();
      checks++;
      if (both_cnt != 0) begin
         failures++;
         $display("FAIL read_write_overlap got=%0d want=0", both_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
